ps2_key_serializer: RTL



---
 rtl/ps2_ser_pkg.sv | 20 ++
 rtl/ps2_byte_fifo.sv | 58 +++++
 rtl/ps2_key_serializer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/ps2_ser_pkg.sv
// Shared types and helpers for the PS/2 key serializer.
// Holds the framing FSM states, PS/2 prefix bytes and the frame parity rule.
package ps2_ser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_BITS,
    ST_GAP
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  // PS/2 uses odd parity: data plus parity bit must hold an odd number of ones.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// Byte FIFO with an atomic 1-3 byte write port and a 1-byte show-ahead read port.
// Read data valid same cycle as !o_empty; a write lands only if all bytes fit (o_wr_rdy), else nothing is written.
module ps2_byte_fifo
  import ps2_ser_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  localparam int AW = $clog2(FIFO_DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr_vld,
  input  logic [1:0]       i_wr_len,
  input  logic [2:0][7:0]  i_wr_dat,
  output logic             o_wr_rdy,
  input  logic             i_rd_en,
  output logic [7:0]       o_rd_dat,
  output logic [AW:0]      o_count,
  output logic             o_empty
);

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [AW:0]   w_free;
  logic          w_wr;
  logic          w_rd;

  // Space is judged on the count before this cycle's pop.
  assign w_free   = (AW+1)'(FIFO_DEPTH) - r_count;
  assign o_wr_rdy = (w_free >= (AW+1)'(i_wr_len));
  assign w_wr     = i_wr_vld & o_wr_rdy;
  assign w_rd     = i_rd_en & ~o_empty;
  assign o_rd_dat = r_mem[r_rd_ptr];
  assign o_count  = r_count;
  assign o_empty  = (r_count == '0);

  always_ff @(posedge i_clk) begin
    for (int k = 0; k < 3; k++) begin
      if (w_wr && (k < int'(i_wr_len))) begin
        r_mem[r_wr_ptr + AW'(k)] <= i_wr_dat[k];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(i_wr_len);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (w_wr ? (AW+1)'(i_wr_len) : '0) - (w_rd ? (AW+1)'(1) : '0);
    end
  end

endmodule

// File: rtl/ps2_key_serializer.sv
// Turns ps2_key toggle events into make/break byte runs and shifts them out as 11-bit PS/2 frames.
// Start bit appears 2 cycles after an event when idle; events that do not fit the FIFO are dropped whole with an overflow pulse.
module ps2_key_serializer
  import ps2_ser_pkg::*;
#(
  parameter int CLK_DIV    = 4000,
  parameter int GAP_CYCLES = 8000,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  output logic        ps2_clk_out,
  output logic        ps2_data_out,
  output logic        busy,
  output logic        overflow
);

  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

  logic            r_key_tgl;
  logic            r_ovf;
  logic            w_evt;
  logic [1:0]      w_len;
  logic [2:0][7:0] w_bytes;
  logic            w_wr_rdy;
  logic [7:0]      w_rd_dat;
  logic [AW:0]     w_count;
  logic            w_empty;

  ps2_state_e      r_state, w_state_nxt;
  logic [CW-1:0]   r_div, w_div_nxt;
  logic            r_phase, w_phase_nxt;
  logic [3:0]      r_bit, w_bit_nxt, w_bit_inc;
  logic            r_clk, w_clk_nxt;
  logic            r_data, w_data_nxt;
  logic [7:0]      r_shift;
  logic            r_par;
  logic            w_pop;
  logic [9:0]      w_frame;

  assign w_evt = ps2_key[10] ^ r_key_tgl;

  always_comb begin
    w_bytes = '0;
    w_len   = 2'd1;
    unique case ({ps2_key[8], ps2_key[9]})
      2'b00: begin w_bytes[0] = PS2_BRK; w_bytes[1] = ps2_key[7:0]; w_len = 2'd2; end
      2'b01: begin w_bytes[0] = ps2_key[7:0]; w_len = 2'd1; end
      2'b10: begin
        w_bytes[0] = PS2_EXT; w_bytes[1] = PS2_BRK; w_bytes[2] = ps2_key[7:0]; w_len = 2'd3;
      end
      2'b11: begin w_bytes[0] = PS2_EXT; w_bytes[1] = ps2_key[7:0]; w_len = 2'd2; end
    endcase
  end

  ps2_byte_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk    (clk_sys),
    .i_rst    (reset),
    .i_wr_vld (w_evt),
    .i_wr_len (w_len),
    .i_wr_dat (w_bytes),
    .o_wr_rdy (w_wr_rdy),
    .i_rd_en  (w_pop),
    .o_rd_dat (w_rd_dat),
    .o_count  (w_count),
    .o_empty  (w_empty)
  );

  // Frame bits after the start bit: data LSB first, parity, stop.
  assign w_frame   = {1'b1, r_par, r_shift};
  assign w_bit_inc = r_bit + 4'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_div + CW'(1);
    w_phase_nxt = r_phase;
    w_bit_nxt   = r_bit;
    w_clk_nxt   = r_clk;
    w_data_nxt  = r_data;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_div_nxt  = '0;
        w_clk_nxt  = 1'b1;
        w_data_nxt = 1'b1;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_START;
          w_phase_nxt = 1'b0;
          w_data_nxt  = 1'b0;
        end
      end
      ST_START, ST_BITS: begin
        if (r_div == DIV_LAST) begin
          w_div_nxt = '0;
          if (!r_phase) begin
            w_phase_nxt = 1'b1;
            w_clk_nxt   = 1'b0;
          end else begin
            // Rising clock edge: the next data bit is launched together with it.
            w_phase_nxt = 1'b0;
            w_clk_nxt   = 1'b1;
            if (r_state == ST_START) begin
              w_state_nxt = ST_BITS;
              w_bit_nxt   = 4'd0;
              w_data_nxt  = w_frame[0];
            end else if (r_bit == 4'd9) begin
              w_state_nxt = ST_GAP;
              w_data_nxt  = 1'b1;
            end else begin
              w_bit_nxt  = w_bit_inc;
              w_data_nxt = w_frame[w_bit_inc];
            end
          end
        end
      end
      ST_GAP: begin
        if (r_div == GAP_LAST) begin
          w_state_nxt = ST_IDLE;
          w_div_nxt   = '0;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_div     <= '0;
      r_phase   <= 1'b0;
      r_bit     <= 4'd0;
      r_clk     <= 1'b1;
      r_data    <= 1'b1;
      r_shift   <= 8'h00;
      r_par     <= 1'b0;
      r_ovf     <= 1'b0;
      r_key_tgl <= ps2_key[10];
    end else begin
      r_state   <= w_state_nxt;
      r_div     <= w_div_nxt;
      r_phase   <= w_phase_nxt;
      r_bit     <= w_bit_nxt;
      r_clk     <= w_clk_nxt;
      r_data    <= w_data_nxt;
      r_ovf     <= w_evt & ~w_wr_rdy;
      r_key_tgl <= ps2_key[10];
      if (w_pop) begin
        r_shift <= w_rd_dat;
        r_par   <= odd_parity(w_rd_dat);
      end
    end
  end

  assign ps2_clk_out  = r_clk;
  assign ps2_data_out = r_data;
  assign overflow     = r_ovf;
  assign busy         = (w_count != '0) | (r_state != ST_IDLE);

endmodule
